pressure_sensor_gen: RTL and testbench
======================================

PRESSURE_SENSOR_GEN -- requirements
Module: pressure_sensor_gen

Interface
REQ-001 Parameter INIT_P, default 128: pressure value loaded at reset.
REQ-002 Parameter FILL_STEP, default 2: pressure added per cycle per active compressor.
REQ-003 Parameters TH_HIGH=200, TH_LOW=120, TH_VLOW=60, HYST=4: classification thresholds and hysteresis band (8-bit unsigned).
REQ-004 Parameter SAMPLE_DIV, default 4: cycles per classification sample tick (legal range 1..16).
REQ-005 Parameter FAULT_LIMIT, default 8: consecutive faulty samples before Fault asserts.
REQ-006 Clk  input  1  single clock; all state changes on posedge Clk.
REQ-007 Reset  input  1  synchronous, active-low reset (sampled on posedge Clk, 0 = reset).
REQ-008 C1, C2, C3  input  1 each  compressor run commands from the alternating compressor controller.
REQ-009 Demand  input  2  air consumption per cycle (0..3 units).
REQ-010 PA  output  1  pressure high (registered).
REQ-011 PB  output  1  pressure low (registered).
REQ-012 PMB  output  1  pressure very low (registered).
REQ-013 Pressure  output  8  current modelled tank pressure.
REQ-014 Tick  output  1  one-cycle pulse on each sample tick.
REQ-015 Fault  output  1  sticky fault flag (see Configuration).

Function
REQ-016 Each cycle: Pressure <= sat(Pressure + FILL_STEP*(C1+C2+C3) - Demand); evaluated in 10-bit signed arithmetic, clamped to 0..255; input-to-Pressure latency 1 cycle.
REQ-017 Divider counter counts 0..SAMPLE_DIV-1, wraps to 0; Tick=1 in the cycle the counter equals SAMPLE_DIV-1.
REQ-018 Classifier FSM states: S_HIGH, S_NORM, S_LOW, S_VLOW; evaluated only in Tick cycles using the current Pressure register value; holds otherwise.
REQ-019 Transitions: NORM->HIGH if P>=TH_HIGH; HIGH->NORM if P<TH_HIGH-HYST; NORM->LOW if P<TH_LOW; LOW->NORM if P>=TH_LOW+HYST; LOW->VLOW if P<TH_VLOW; VLOW->LOW if P>=TH_VLOW+HYST.
REQ-020 Any state SHALL jump directly to S_VLOW if P<TH_VLOW and to S_HIGH if P>=TH_HIGH, overriding single-step transitions.
REQ-021 Outputs decoded registered from the FSM state: HIGH->PA=1; LOW->PB=1; VLOW->PMB=1; NORM->all 0; at most one of PA/PB/PMB high at any time.
REQ-022 PA/PB/PMB change exactly 1 cycle after the Tick cycle that caused the transition.
REQ-023 Pressure saturation: at 255 with net positive input stays 255; at 0 with net negative input stays 0; no wrap-around.

Reset
REQ-024 While Reset=0 at posedge: Pressure=INIT_P, divider=0, Tick=0, FSM=S_NORM, PA=PB=PMB=0, Fault=0, fault counter=0.
REQ-025 Reset asserted mid-operation SHALL override all updates that cycle; first Tick occurs SAMPLE_DIV cycles after Reset returns to 1.

Configuration
REQ-026 Macro PRESSURE_FAULT_EN defined: fault counter increments on each Tick where FSM=S_VLOW and C1=C2=C3=1, clears on any Tick where that condition is false; when it reaches FAULT_LIMIT, Fault=1, sticky until reset; counter saturates.
REQ-027 Macro PRESSURE_FAULT_EN undefined: no fault logic synthesized; Fault tied to 0.

Verification
REQ-028 Reset=0 for 2 cycles, then 1, C=000, Demand=0 -> Pressure=128, PA=PB=PMB=0, first Tick 4 cycles after release.
REQ-029 C1=C2=C3=1, Demand=0 from P=128 -> P increments by 6 per cycle, PA=1 one cycle after first Tick with P>=200, P holds at 255.
REQ-030 From P=200 in S_HIGH, C=000, Demand=1 -> PA stays 1 until a Tick sees P<196, then PA=0 with PB=PMB=0.
REQ-031 From P=128, C=000, Demand=3 -> PB=1 after Tick with P<120, PMB=1 (PB=0) after Tick with P<60, P clamps at 0 without wrap.
REQ-032 With PRESSURE_FAULT_EN, force S_VLOW with Demand=3 and C=111 (FILL_STEP=0 override) for 8 Ticks -> Fault=1 and stays 1 after C=000; without the macro Fault=0 throughout.
REQ-033 Reset=0 pulsed for 1 cycle while PMB=1 -> next cycle Pressure=128, PMB=0, FSM=S_NORM, Fault=0.

Source files
------------

// File: rtl/pressure_sensor_gen.sv
// pressure_sensor_gen
//   Models the pressure in a compressed-air tank and classifies it into
//   high / normal / low / very-low bands, as a stimulus source for an
//   alternating compressor controller.
//
//   Every cycle the tank gains FILL_STEP per running compressor and loses
//   Demand units. The result saturates to 0..255. A divider produces a
//   one-cycle Tick every SAMPLE_DIV cycles. The band classifier only moves
//   on Tick cycles and uses hysteresis on the way back up.
//
//   Optional fault detection is compiled in with the macro PRESSURE_FAULT_EN.
//   Fault latches after FAULT_LIMIT consecutive Ticks that find the tank
//   very low while all three compressors are running. Without the macro,
//   Fault is tied to 0.
//
// Ports
//   Clk        in   single clock, everything changes on posedge
//   Reset      in   synchronous reset, active low
//   C1,C2,C3   in   compressor run commands
//   Demand     in   [1:0] air drawn from the tank per cycle
//   PA         out  pressure high (registered)
//   PB         out  pressure low (registered)
//   PMB        out  pressure very low (registered)
//   Pressure   out  [7:0] modelled tank pressure
//   Tick       out  one-cycle sample pulse
//   Fault      out  sticky fault flag
//   fsm_state  out  [1:0] classifier state for debug/checkers
//                   (0 = HIGH, 1 = NORM, 2 = LOW, 3 = VLOW)
module pressure_sensor_gen #(
  parameter int unsigned INIT_P      = 128,
  parameter int unsigned FILL_STEP   = 2,
  parameter int unsigned TH_HIGH     = 200,
  parameter int unsigned TH_LOW      = 120,
  parameter int unsigned TH_VLOW     = 60,
  parameter int unsigned HYST        = 4,
  parameter int unsigned SAMPLE_DIV  = 4,
  parameter int unsigned FAULT_LIMIT = 8
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       C1,
  input  logic       C2,
  input  logic       C3,
  input  logic [1:0] Demand,
  output logic       PA,
  output logic       PB,
  output logic       PMB,
  output logic [7:0] Pressure,
  output logic       Tick,
  output logic       Fault,
  output logic [1:0] fsm_state
);

  typedef enum logic [1:0] {
    S_HIGH = 2'd0,
    S_NORM = 2'd1,
    S_LOW  = 2'd2,
    S_VLOW = 2'd3
  } state_t;

  localparam logic [7:0] P_INIT    = 8'(INIT_P);
  localparam logic [7:0] LIM_HIGH  = 8'(TH_HIGH);
  localparam logic [7:0] LIM_HDOWN = 8'(TH_HIGH - HYST);
  localparam logic [7:0] LIM_LOW   = 8'(TH_LOW);
  localparam logic [7:0] LIM_LUP   = 8'(TH_LOW + HYST);
  localparam logic [7:0] LIM_VLOW  = 8'(TH_VLOW);
  localparam logic [7:0] LIM_VUP   = 8'(TH_VLOW + HYST);
  localparam logic [3:0] DIV_LAST  = 4'(SAMPLE_DIV - 1);

  // ---------------------------------------------------------------------
  // Tank pressure: 10-bit signed sum so both underflow below 0 and
  // overflow above 255 are visible before clamping.
  // ---------------------------------------------------------------------
  logic [1:0]        n_on;
  logic signed [9:0] fill_term;
  logic signed [9:0] p_sum;
  logic [7:0]        p_nxt;

  always_comb begin
    n_on      = {1'b0, C1} + {1'b0, C2} + {1'b0, C3};
    fill_term = 10'(FILL_STEP * n_on);
    p_sum     = $signed({2'b00, Pressure}) + fill_term - $signed({8'b0, Demand});
    if (p_sum < 10'sd0)
      p_nxt = 8'd0;
    else if (p_sum > 10'sd255)
      p_nxt = 8'd255;
    else
      p_nxt = p_sum[7:0];
  end

  always_ff @(posedge Clk) begin
    if (!Reset)
      Pressure <= P_INIT;
    else
      Pressure <= p_nxt;
  end

  // ---------------------------------------------------------------------
  // Sample divider. Tick is registered from the next count, so it is high
  // exactly while the counter holds SAMPLE_DIV-1 and is forced low in reset
  // (this matters when SAMPLE_DIV is 1).
  // ---------------------------------------------------------------------
  logic [3:0] div_q;
  logic [3:0] div_nxt;

  always_comb begin
    div_nxt = (div_q == DIV_LAST) ? 4'd0 : div_q + 4'd1;
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      div_q <= 4'd0;
      Tick  <= 1'b0;
    end else begin
      div_q <= div_nxt;
      Tick  <= (div_nxt == DIV_LAST);
    end
  end

  // ---------------------------------------------------------------------
  // Band classifier. The very-low and high checks come first so a large
  // excursion between ticks jumps straight to the extreme band.
  // ---------------------------------------------------------------------
  state_t state_q;
  state_t state_nxt;

  always_comb begin
    state_nxt = state_q;
    if (Tick) begin
      if (Pressure < LIM_VLOW)
        state_nxt = S_VLOW;
      else if (Pressure >= LIM_HIGH)
        state_nxt = S_HIGH;
      else begin
        case (state_q)
          S_NORM:  if (Pressure < LIM_LOW)   state_nxt = S_LOW;
          S_HIGH:  if (Pressure < LIM_HDOWN) state_nxt = S_NORM;
          S_LOW:   if (Pressure >= LIM_LUP)  state_nxt = S_NORM;
          S_VLOW:  if (Pressure >= LIM_VUP)  state_nxt = S_LOW;
          default: state_nxt = S_NORM;
        endcase
      end
    end
  end

  // Flags are registered from the next state, so they move on the same
  // edge as the state register: one cycle after the deciding Tick.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= S_NORM;
      PA      <= 1'b0;
      PB      <= 1'b0;
      PMB     <= 1'b0;
    end else begin
      state_q <= state_nxt;
      PA      <= (state_nxt == S_HIGH);
      PB      <= (state_nxt == S_LOW);
      PMB     <= (state_nxt == S_VLOW);
    end
  end

  assign fsm_state = state_q;

  // ---------------------------------------------------------------------
  // Fault detection: all compressors running yet the tank stays very low.
  // ---------------------------------------------------------------------
`ifdef PRESSURE_FAULT_EN
  localparam logic [7:0] FLT_LIM = 8'(FAULT_LIMIT);

  logic [7:0] flt_cnt;
  logic [7:0] flt_cnt_nxt;
  logic       flt_cond;

  always_comb begin
    flt_cond    = (state_q == S_VLOW) && C1 && C2 && C3;
    flt_cnt_nxt = flt_cnt;
    if (Tick) begin
      if (!flt_cond)
        flt_cnt_nxt = 8'd0;
      else if (flt_cnt != FLT_LIM)
        flt_cnt_nxt = flt_cnt + 8'd1;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      flt_cnt <= 8'd0;
      Fault   <= 1'b0;
    end else begin
      flt_cnt <= flt_cnt_nxt;
      Fault   <= Fault | (flt_cnt_nxt == FLT_LIM);
    end
  end
`else
  assign Fault = 1'b0;
`endif

endmodule

// File: tb/tb_pressure_sensor_gen.sv
// tb_pressure_sensor_gen
//   Directed bench for pressure_sensor_gen with default parameters.
//   A small reference model (pressure, divider phase, band state) is
//   stepped once per clock and compared with the DUT after every edge.
//   A table of hand-computed vectors and several hand-written ramps cover
//   fill saturation, drain clamping, hysteresis, and reset recovery. When
//   PRESSURE_FAULT_EN is defined, a second instance with FILL_STEP=0
//   exercises the sticky fault.
module tb_pressure_sensor_gen;

  logic       Clk;
  logic       Reset;
  logic       C1, C2, C3;
  logic [1:0] Demand;
  logic       PA, PB, PMB;
  logic [7:0] Pressure;
  logic       Tick;
  logic       Fault;
  logic [1:0] fsm_state;

  pressure_sensor_gen u_dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .C1        (C1),
    .C2        (C2),
    .C3        (C3),
    .Demand    (Demand),
    .PA        (PA),
    .PB        (PB),
    .PMB       (PMB),
    .Pressure  (Pressure),
    .Tick      (Tick),
    .Fault     (Fault),
    .fsm_state (fsm_state)
  );

  // ---------------- clock ----------------
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // ---------------- scoreboard counters ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Band encoding: 0 HIGH, 1 NORM, 2 LOW, 3 VLOW.
  int m_p;
  int m_div;
  bit m_tick;
  int m_state;

  function automatic int sat(input int v);
    if (v < 0)   return 0;
    if (v > 255) return 255;
    return v;
  endfunction

  function automatic int cls_next(input int st, input int p);
    if (p < 60)  return 3;
    if (p >= 200) return 0;
    case (st)
      1: return (p < 120) ? 2 : 1;
      0: return (p < 196) ? 1 : 0;
      2: return (p >= 124) ? 1 : 2;
      3: return (p >= 64) ? 2 : 3;
      default: return 1;
    endcase
  endfunction

  task automatic chk_all(input string tag);
    chk({tag, "_pressure"}, int'(Pressure), m_p);
    chk({tag, "_tick"},     int'(Tick), int'(m_tick));
    chk({tag, "_pa"},       int'(PA),  int'(m_state == 0));
    chk({tag, "_pb"},       int'(PB),  int'(m_state == 2));
    chk({tag, "_pmb"},      int'(PMB), int'(m_state == 3));
    chk({tag, "_state"},    int'(fsm_state), m_state);
    chk({tag, "_fault"},    int'(Fault), 0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic [2:0] c, input logic [1:0] d);
    int n;
    C1 = c[0];
    C2 = c[1];
    C3 = c[2];
    Demand = d;
    @(posedge Clk);
    n = int'(c[0]) + int'(c[1]) + int'(c[2]);
    if (m_tick) m_state = cls_next(m_state, m_p);
    m_p   = sat(m_p + 2 * n - int'(d));
    m_div = (m_div == 3) ? 0 : m_div + 1;
    m_tick = (m_div == 3);
    #1;
    chk_all("step");
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    {C3, C2, C1} = 3'b000;
    Demand = 2'd0;
    @(posedge Clk);
    m_p = 128;
    m_div = 0;
    m_tick = 1'b0;
    m_state = 1;
    #1;
    chk_all("reset");
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [2:0] c;
    logic [1:0] d;
    logic [7:0] p;
    logic       tick;
  } vec_t;

  vec_t vt[8];

`ifdef PRESSURE_FAULT_EN
  // Fill-less instance: the tank can only drain, so VLOW with all three
  // compressors commanded persists long enough to trip the fault.
  logic       f_reset;
  logic [2:0] f_c;
  logic [1:0] f_d;
  logic       f_pa, f_pb, f_pmb, f_tick, f_fault;
  logic [7:0] f_pressure;
  logic [1:0] f_state;

  pressure_sensor_gen #(.FILL_STEP(0)) u_flt (
    .Clk       (Clk),
    .Reset     (f_reset),
    .C1        (f_c[0]),
    .C2        (f_c[1]),
    .C3        (f_c[2]),
    .Demand    (f_d),
    .PA        (f_pa),
    .PB        (f_pb),
    .PMB       (f_pmb),
    .Pressure  (f_pressure),
    .Tick      (f_tick),
    .Fault     (f_fault),
    .fsm_state (f_state)
  );

  initial begin
    f_reset = 1'b0;
    f_c = 3'b000;
    f_d = 2'd0;
  end

  task automatic run_fault_test();
    f_reset = 1'b0;
    f_c = 3'b000;
    f_d = 2'd0;
    @(posedge Clk); #1;
    chk("flt_reset", int'(f_fault), 0);
    f_reset = 1'b1;
    f_c = 3'b111;
    f_d = 2'd3;
    // VLOW from edge 24; four counted Ticks by edge 40.
    repeat (40) @(posedge Clk);
    #1;
    chk("flt_early", int'(f_fault), 0);
    chk("flt_vlow", int'(f_pmb), 1);
    repeat (60) @(posedge Clk);
    #1;
    chk("flt_set", int'(f_fault), 1);
    f_c = 3'b000;
    repeat (20) @(posedge Clk);
    #1;
    chk("flt_sticky", int'(f_fault), 1);
    f_reset = 1'b0;
    @(posedge Clk); #1;
    chk("flt_clear", int'(f_fault), 0);
    f_reset = 1'b1;
  endtask
`endif

  // ---------------- main sequence ----------------
  initial begin
    logic [3:0] first_tick;

    Reset = 1'b0;
    {C3, C2, C1} = 3'b000;
    Demand = 2'd0;

    // Starts at P=128 right after the 4-cycle reset/tick check below.
    vt[0] = '{c: 3'b001, d: 2'd0, p: 8'd130, tick: 1'b0};
    vt[1] = '{c: 3'b011, d: 2'd1, p: 8'd133, tick: 1'b0};
    vt[2] = '{c: 3'b111, d: 2'd3, p: 8'd136, tick: 1'b1};
    vt[3] = '{c: 3'b000, d: 2'd3, p: 8'd133, tick: 1'b0};
    vt[4] = '{c: 3'b100, d: 2'd2, p: 8'd133, tick: 1'b0};
    vt[5] = '{c: 3'b010, d: 2'd0, p: 8'd135, tick: 1'b0};
    vt[6] = '{c: 3'b101, d: 2'd1, p: 8'd138, tick: 1'b1};
    vt[7] = '{c: 3'b000, d: 2'd2, p: 8'd136, tick: 1'b0};

    // Two reset cycles, then release; the first Tick is the 3rd edge.
    do_reset();
    do_reset();
    chk("rst_p", int'(Pressure), 128);
    chk("rst_flags", int'({PA, PB, PMB}), 0);
    Reset = 1'b1;
    first_tick = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      step(3'b000, 2'd0);
      chk("first_tick", int'(Tick), int'(first_tick[i]));
    end

    // Table vectors.
    for (int i = 0; i < 8; i++) begin
      step(vt[i].c, vt[i].d);
      chk("vec_p", int'(Pressure), int'(vt[i].p));
      chk("vec_tick", int'(Tick), int'(vt[i].tick));
    end

    // Fill with all compressors: +6 per cycle, PA after a tick sees >=200,
    // then saturation at 255.
    for (int i = 0; i < 30; i++) step(3'b111, 2'd0);
    chk("fill_sat_p", int'(Pressure), 255);
    chk("fill_pa", int'(PA), 1);

    // Slow drain from HIGH: PA must hold through 196..199.
    for (int i = 0; i < 70; i++) step(3'b000, 2'd1);
    chk("drain1_p", int'(Pressure), 185);
    chk("drain1_flags", int'({PA, PB, PMB}), 0);

    // Fast drain through LOW to VLOW and clamp at zero.
    for (int i = 0; i < 70; i++) step(3'b000, 2'd3);
    chk("drain3_p", int'(Pressure), 0);
    chk("drain3_pmb", int'(PMB), 1);
    chk("drain3_pb", int'(PB), 0);

    // Single-cycle reset pulse while very low.
    do_reset();
    chk("pulse_p", int'(Pressure), 128);
    chk("pulse_pmb", int'(PMB), 0);
    chk("pulse_state", int'(fsm_state), 1);
    chk("pulse_tick", int'(Tick), 0);
    Reset = 1'b1;

    // Hysteresis around TH_LOW: fall to LOW, rise at +1/cycle.
    // The tick seeing 123 must keep PB; the tick seeing 127 clears it.
    for (int i = 0; i < 20; i++) step(3'b000, 2'd1);
    chk("hyst_low_pb", int'(PB), 1);
    for (int i = 0; i < 16; i++) step(3'b100, 2'd1);
    chk("hyst_hold_p", int'(Pressure), 124);
    chk("hyst_hold_pb", int'(PB), 1);
    for (int i = 0; i < 8; i++) step(3'b100, 2'd1);
    chk("hyst_norm_pb", int'(PB), 0);

`ifdef PRESSURE_FAULT_EN
    run_fault_test();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
